// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event encoder.
// Holds the FSM state enum plus the one-hot and popcount helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  // Helpers work on a fixed-width vector; callers zero-extend.
  localparam int KEY_MAX = 64;
  localparam int IDX_W   = 6;

  typedef struct packed {
    logic             is_onehot;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  function automatic onehot_t onehot_index(
    input logic [KEY_MAX-1:0] v
  );
    onehot_t r;
    int      n;
    r = '0;
    n = 0;
    for (int i = 0; i < KEY_MAX; i++) begin
      if (v[i]) begin
        r.idx = IDX_W'(i);
        n++;
      end
    end
    r.is_onehot = (n == 1);
    return r;
  endfunction

  function automatic logic popcount_gt1(
    input logic [KEY_MAX-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < KEY_MAX; i++) begin
      n += int'(v[i]);
    end
    return n > 1;
  endfunction

endpackage

// File: rtl/keypad_event_encoder_fifo.sv
// sync_fifo: first-word-fall-through queue, push/pop, exact count.
// Ports: clk, rst, push, din, pop, dout, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  // A push into a full queue fits only if a pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Debounces a key-strobe bus and queues single-key presses as codes.
// Ports: clk, rst, key_in, evt_code/valid/ready/count, multi_err, overflow.
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 16,
  parameter int CODE_W          = $clog2(N_KEYS),
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_KEYS-1:0]           key_in,
  output logic [CODE_W-1:0]           evt_code,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        multi_err,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_KEYS-1:0]  key_m;
  logic [N_KEYS-1:0]  key_s;
  logic [N_KEYS-1:0]  cand_q;
  logic [N_KEYS-1:0]  cand_d;
  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               eval;
  logic [KEY_MAX-1:0] cand_ext;
  onehot_t            oh;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               multi_d;
  logic               ovf_d;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s != '0) begin
          cand_d  = key_s;
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key_s == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (key_s != cand_q) begin
          cand_d = key_s;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // cnt counts consecutive released samples here.
        if (key_s != '0) begin
          cnt_d = '0;
        end else if (cnt_q + CNT_W'(1) == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Shared exit covers the single-sample case straight from IDLE.
    if (state_d == DEBOUNCE && cnt_d == CNT_MAX) begin
      eval    = 1'b1;
      cnt_d   = '0;
      state_d = HELD;
    end
  end

  assign cand_ext = KEY_MAX'(cand_d);
  assign oh       = onehot_index(cand_ext);
  assign push     = eval && oh.is_onehot
                    && (oh.idx < IDX_W'(N_KEYS));
  assign multi_d  = eval && popcount_gt1(cand_ext);
  assign pop      = evt_valid && evt_ready;
  assign ovf_d    = push && full && !pop;
  assign evt_valid = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_m     <= '0;
      key_s     <= '0;
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      multi_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      key_m     <= key_in;
      key_s     <= key_m;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      multi_err <= multi_d;
      overflow  <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (oh.idx[CODE_W-1:0]),
    .pop   (pop),
    .dout  (evt_code),
    .full  (full),
    .empty (empty),
    .count (evt_count)
  );

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Scoreboard bench for keypad_event_encoder.
// Window-based press model feeds an expected-code queue.
module tb_keypad_event_encoder;

  localparam int N     = 16;
  localparam int CW    = 4;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  key_in = '0;
  logic          evt_ready = 1'b0;
  logic [CW-1:0] evt_code;
  logic          evt_valid;
  logic [2:0]    evt_count;
  logic          multi_err;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_event_encoder #(
    .N_KEYS          (N),
    .CODE_W          (CW),
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .multi_err (multi_err),
    .overflow  (overflow)
  );

  // Reference model: a press is accepted when the last D synchronised
  // samples are the same nonzero pattern while armed; D zero samples
  // in a row re-arm.
  int           exp_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] s1 = '0;
  logic [N-1:0] s2 = '0;
  bit           armed = 1'b1;
  bit           exp_multi = 1'b0;
  bit           exp_ovf = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin : model
    logic [N-1:0] ks;
    bit           same;
    bit           zero;
    int           code;
    if (rst) begin
      s1 = '0;
      s2 = '0;
      hist.delete();
      exp_q.delete();
      armed = 1'b1;
      exp_multi = 1'b0;
      exp_ovf = 1'b0;
      chk_en = 1'b1;
    end else begin
      exp_multi = 1'b0;
      exp_ovf = 1'b0;
      ks = s2;
      s2 = s1;
      s1 = key_in;
      hist.push_back(ks);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        same = 1'b1;
        zero = 1'b1;
        foreach (hist[i]) begin
          if (hist[i] != ks) same = 1'b0;
          if (hist[i] != '0) zero = 1'b0;
        end
        if (armed && same && ks != '0) begin
          armed = 1'b0;
          if ($countones(ks) == 1) begin
            code = 0;
            for (int i = 0; i < N; i++) if (ks[i]) code = i;
            // Monitor already removed any item popped on this edge.
            if (exp_q.size() < DEPTH) exp_q.push_back(code);
            else exp_ovf = 1'b1;
          end else begin
            exp_multi = 1'b1;
          end
        end else if (!armed && zero) begin
          armed = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int c;
    if (chk_en) begin
      check("evt_count", 32'(evt_count), exp_q.size());
      check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      check("multi_err", 32'(multi_err), 32'(exp_multi));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (!evt_valid) check("code_empty", 32'(evt_code), 0);
      if (evt_valid && evt_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          c = exp_q.pop_front();
          check("evt_code", 32'(evt_code), c);
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] k,
                       input bit r,
                       input int n);
    repeat (n) begin
      key_in = k;
      evt_ready = r;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int idx);
    logic [N-1:0] k;
    k = '0;
    k[idx] = 1'b1;
    drive(k, 1'b0, 8);
    drive('0, 1'b0, 8);
  endtask

  initial begin
    logic [N-1:0] k;
    int           r;
    int           len;
    rst = 1'b1;
    drive('0, 1'b0, 3);
    rst = 1'b0;

    // clean press, then single-cycle accept
    drive(16'h0008, 1'b0, 10);
    drive(16'h0008, 1'b1, 1);
    drive('0, 1'b0, 8);

    // bouncing press
    for (int i = 0; i < 6; i++)
      drive((i % 2 == 0) ? 16'h0010 : 16'h0000, 1'b0, 1);
    drive(16'h0010, 1'b0, 10);
    drive('0, 1'b1, 8);

    // multi-key then a clean key
    drive(16'h8001, 1'b0, 10);
    drive('0, 1'b0, 8);
    drive(16'h4000, 1'b0, 10);
    drive('0, 1'b1, 8);

    // held key with a glitch, no repeat
    drive(16'h0200, 1'b0, 50);
    drive(16'h0300, 1'b0, 3);
    drive(16'h0200, 1'b0, 5);
    drive('0, 1'b0, 8);
    drive(16'h0200, 1'b0, 10);
    drive('0, 1'b1, 8);

    // overflow on the fifth press, then drain
    press(0);
    press(1);
    press(2);
    press(3);
    press(5);
    drive('0, 1'b1, 6);

    // full queue with pop on the push edge
    press(0);
    press(1);
    press(2);
    press(3);
    drive(16'h0080, 1'b0, 5);
    drive(16'h0080, 1'b1, 1);
    drive(16'h0080, 1'b0, 4);
    drive('0, 1'b0, 8);
    drive('0, 1'b1, 6);

    // reset mid-debounce with two queued events
    press(1);
    press(2);
    drive(16'h0040, 1'b0, 3);
    rst = 1'b1;
    drive(16'h0040, 1'b0, 1);
    rst = 1'b0;
    drive(16'h0040, 1'b0, 10);
    drive('0, 1'b1, 10);

    // randomized segments
    repeat (400) begin
      r = $urandom_range(0, 9);
      k = '0;
      if (r < 5) begin
        k[$urandom_range(0, N - 1)] = 1'b1;
      end else if (r < 7) begin
        k[$urandom_range(0, N - 1)] = 1'b1;
        k[$urandom_range(0, N - 1)] = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        drive(k, 1'b0, 1);
        rst = 1'b0;
      end
      len = $urandom_range(1, 12);
      repeat (len) drive(k, ($urandom_range(0, 2) == 0), 1);
    end

    drive('0, 1'b1, 20);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
